// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 byte transmitter driving open-drain clk/data through pull-low enables.
// Latency: INHIBIT_CYCLES of clock inhibit, then 11 device clocks, then done/err once the bus is idle.
// Backpressure: a tx_start that arrives while busy is dropped; the caller waits for busy to fall.
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 5000,
    parameter int TIMEOUT_CYCLES = 750000
) (
    input  logic       clk,
    input  logic       clrn,
    input  logic       ps2_clk_in,
    input  logic       ps2_dat_in,
    output logic       ps2_clk_oe,
    output logic       ps2_dat_oe,
    input  logic [7:0] tx_data,
    input  logic       tx_start,
    output logic       busy,
    output logic       done,
    output logic       err
);

    localparam int CNT_MAX = (TIMEOUT_CYCLES > INHIBIT_CYCLES) ? TIMEOUT_CYCLES : INHIBIT_CYCLES;
    localparam int CW      = $clog2(CNT_MAX + 1);
    // The RTS cycle is the last of the inhibit window, so INHIBIT itself lasts one cycle less.
    localparam logic [CW-1:0] INH_LAST = CW'(INHIBIT_CYCLES - 2);
    localparam logic [CW-1:0] TO_LAST  = CW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {IDLE, INHIBIT, RTS, BITS, ACK, WAIT_IDLE} state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic [3:0]    idx, idx_nxt;
    logic [10:0]   frame, frame_nxt;
    logic          ack_ok, ack_nxt;
    logic          clk_oe_nxt, dat_oe_nxt, busy_nxt, done_nxt, err_nxt;

    logic clk_s1, clk_s2, clk_d, dat_s1, dat_s2, fall;

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            clk_s1 <= 1'b1;
            clk_s2 <= 1'b1;
            clk_d  <= 1'b1;
            dat_s1 <= 1'b1;
            dat_s2 <= 1'b1;
            fall   <= 1'b0;
        end else begin
            clk_s1 <= ps2_clk_in;
            clk_s2 <= clk_s1;
            clk_d  <= clk_s2;
            fall   <= clk_d & ~clk_s2;
            dat_s1 <= ps2_dat_in;
            dat_s2 <= dat_s1;
        end
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state      <= IDLE;
            cnt        <= '0;
            idx        <= '0;
            frame      <= '0;
            ack_ok     <= 1'b0;
            ps2_clk_oe <= 1'b0;
            ps2_dat_oe <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            idx        <= idx_nxt;
            frame      <= frame_nxt;
            ack_ok     <= ack_nxt;
            ps2_clk_oe <= clk_oe_nxt;
            ps2_dat_oe <= dat_oe_nxt;
            busy       <= busy_nxt;
            done       <= done_nxt;
            err        <= err_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        idx_nxt    = idx;
        frame_nxt  = frame;
        ack_nxt    = ack_ok;
        clk_oe_nxt = ps2_clk_oe;
        dat_oe_nxt = ps2_dat_oe;
        busy_nxt   = busy;
        done_nxt   = 1'b0;
        err_nxt    = 1'b0;
        case (state)
            IDLE: begin
                clk_oe_nxt = 1'b0;
                dat_oe_nxt = 1'b0;
                busy_nxt   = 1'b0;
                if (tx_start) begin
                    frame_nxt  = {1'b1, ~^tx_data, tx_data, 1'b0};
                    cnt_nxt    = '0;
                    clk_oe_nxt = 1'b1;
                    busy_nxt   = 1'b1;
                    state_nxt  = INHIBIT;
                end
            end
            INHIBIT: begin
                cnt_nxt = cnt + 1'b1;
                if (cnt == INH_LAST) begin
                    dat_oe_nxt = 1'b1;
                    state_nxt  = RTS;
                end
            end
            RTS: begin
                clk_oe_nxt = 1'b0;
                dat_oe_nxt = 1'b1;
                idx_nxt    = '0;
                cnt_nxt    = '0;
                state_nxt  = BITS;
            end
            BITS, ACK, WAIT_IDLE: begin
                cnt_nxt = fall ? '0 : cnt + 1'b1;
                if (cnt == TO_LAST) begin
                    // Timeout wins over any edge arriving in the same cycle.
                    clk_oe_nxt = 1'b0;
                    dat_oe_nxt = 1'b0;
                    busy_nxt   = 1'b0;
                    err_nxt    = 1'b1;
                    state_nxt  = IDLE;
                end else if (state == BITS) begin
                    if (fall) begin
                        idx_nxt    = idx + 4'd1;
                        dat_oe_nxt = ~frame[idx_nxt];
                        if (idx_nxt == 4'd10) state_nxt = ACK;
                    end
                end else if (state == ACK) begin
                    if (fall) begin
                        ack_nxt   = ~dat_s2;
                        state_nxt = WAIT_IDLE;
                    end
                end else if (clk_s2 && dat_s2) begin
                    done_nxt  = ack_ok;
                    err_nxt   = ~ack_ok;
                    busy_nxt  = 1'b0;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule
